// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: bit stuffing with configurable run length, NRZI onto dp/dm,
// automatic EOP (SE0 then J), all advancing only on bit_en strobes.
module usb_tx_line_encoder #(
    parameter int RUN_LEN      = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic start,
    input  logic last,
    input  logic bit_in,
    input  logic stuff_en,
    output logic stall,
    output logic dp,
    output logic dm,
    output logic oe,
    output logic done
);

    typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP_SE0, EOP_J} state_t;

    state_t     state_q;
    logic [3:0] run_q;
    logic       lvl_q;
    logic       stuff_q;
    logic       last_pend_q;
    logic [2:0] cnt_q;
    logic       dp_q;
    logic       dm_q;
    logic       oe_q;
    logic       done_q;

    logic       accept;
    logic       stuff_cur;
    logic       lvl_acc;
    logic [3:0] run_base;
    logic [3:0] run_acc;
    logic       hit;

    // IDLE and DATA share one accept path; in IDLE the stuff mode comes straight from the port.
    always_comb begin
        accept    = bit_en && ((state_q == DATA) || ((state_q == IDLE) && start));
        stuff_cur = (state_q == IDLE) ? stuff_en : stuff_q;
        lvl_acc   = bit_in ? lvl_q : ~lvl_q;
        run_base  = (state_q == IDLE) ? '0 : run_q;
        run_acc   = '0;
        if (stuff_cur && bit_in)
            run_acc = run_base + 4'd1;
        hit       = stuff_cur && (run_acc == 4'(RUN_LEN));
    end

    always_comb begin
        stall = (state_q == STUFF) || (state_q == EOP_SE0) || (state_q == EOP_J);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            run_q       <= '0;
            lvl_q       <= 1'b1;
            stuff_q     <= 1'b0;
            last_pend_q <= 1'b0;
            cnt_q       <= '0;
            dp_q        <= 1'b1;
            dm_q        <= 1'b0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (state_q == IDLE)
                    stuff_q <= stuff_en;
                lvl_q       <= lvl_acc;
                dp_q        <= lvl_acc;
                dm_q        <= ~lvl_acc;
                oe_q        <= 1'b1;
                run_q       <= run_acc;
                last_pend_q <= last;
                cnt_q       <= '0;
                if (hit)
                    state_q <= STUFF;
                else if (last)
                    state_q <= EOP_SE0;
                else
                    state_q <= DATA;
            end else if (bit_en) begin
                case (state_q)
                    STUFF: begin
                        lvl_q   <= ~lvl_q;
                        dp_q    <= ~lvl_q;
                        dm_q    <= lvl_q;
                        run_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= last_pend_q ? EOP_SE0 : DATA;
                    end
                    EOP_SE0: begin
                        dp_q <= 1'b0;
                        dm_q <= 1'b0;
                        if (cnt_q == 3'(EOP_SE0_BITS - 1)) begin
                            cnt_q   <= '0;
                            state_q <= EOP_J;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    // First strobe drives J for a bit time, second releases the line.
                    EOP_J: begin
                        dp_q <= 1'b1;
                        dm_q <= 1'b0;
                        if (cnt_q == 3'd0) begin
                            cnt_q <= 3'd1;
                        end else begin
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                            oe_q        <= 1'b0;
                            done_q      <= 1'b1;
                            lvl_q       <= 1'b1;
                            run_q       <= '0;
                            last_pend_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dp   = dp_q;
    assign dm   = dm_q;
    assign oe   = oe_q;
    assign done = done_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Bench for usb_tx_line_encoder: two instances (6/2 and 3/3), line symbols predicted from
// a stuffed-bit-list model and compared on every clock.
module tb_usb_tx_line_encoder;

    logic clk;
    logic rst;
    logic bit_en[2];
    logic start[2];
    logic last[2];
    logic bit_in[2];
    logic stuff_en[2];
    logic stall[2];
    logic dp[2];
    logic dm[2];
    logic oe[2];
    logic done[2];

    usb_tx_line_encoder #(.RUN_LEN(6), .EOP_SE0_BITS(2)) dut0 (
        .clk(clk), .rst(rst), .bit_en(bit_en[0]), .start(start[0]), .last(last[0]),
        .bit_in(bit_in[0]), .stuff_en(stuff_en[0]), .stall(stall[0]), .dp(dp[0]),
        .dm(dm[0]), .oe(oe[0]), .done(done[0])
    );

    usb_tx_line_encoder #(.RUN_LEN(3), .EOP_SE0_BITS(3)) dut1 (
        .clk(clk), .rst(rst), .bit_en(bit_en[1]), .start(start[1]), .last(last[1]),
        .bit_in(bit_in[1]), .stuff_en(stuff_en[1]), .stall(stall[1]), .dp(dp[1]),
        .dm(dm[1]), .oe(oe[1]), .done(done[1])
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;
    logic [4:0] exp_v[2];   // {dp, dm, oe, stall, done}

    bit         pb[$];
    logic [1:0] sym_lvl[$];
    bit         sym_dat[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rl(input int u);
        return (u == 0) ? 6 : 3;
    endfunction

    function automatic int ns(input int u);
        return (u == 0) ? 2 : 3;
    endfunction

    function automatic string ch(input logic [1:0] l);
        case (l)
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                vectors++;
                if ({dp[u], dm[u], oe[u], stall[u], done[u]} !== exp_v[u]) begin
                    miscompares++;
                    $display("FAIL line_u%0d t=%0t dp/dm/oe/stall/done got %b expected %b",
                             u, $time, {dp[u], dm[u], oe[u], stall[u], done[u]}, exp_v[u]);
                end
            end
        end
    end

    // Expected line symbols: stuffed bit list, NRZI from J, then SE0 x N and J.
    task automatic build_model(input int u, input bit sf);
        logic lvl;
        int run;
        sym_lvl.delete();
        sym_dat.delete();
        lvl = 1'b1;
        run = 0;
        foreach (pb[i]) begin
            if (!pb[i]) lvl = ~lvl;
            sym_lvl.push_back({lvl, ~lvl});
            sym_dat.push_back(1'b1);
            if (sf) begin
                run = pb[i] ? run + 1 : 0;
                if (run == rl(u)) begin
                    lvl = ~lvl;
                    sym_lvl.push_back({lvl, ~lvl});
                    sym_dat.push_back(1'b0);
                    run = 0;
                end
            end
        end
        repeat (ns(u)) begin
            sym_lvl.push_back(2'b00);
            sym_dat.push_back(1'b0);
        end
        sym_lvl.push_back(2'b10);
        sym_dat.push_back(1'b0);
    endtask

    task automatic load(input logic [31:0] v, input int n);
        pb.delete();
        for (int i = 0; i < n; i++) pb.push_back(v[i]);
    endtask

    task automatic do_reset(input int u);
        bit_en[u] = 1'b0;
        start[u]  = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({dp[u], dm[u], oe[u], stall[u], done[u]} !== 5'b10000) begin
            miscompares++;
            $display("FAIL async_reset_u%0d got %b expected 10000",
                     u, {dp[u], dm[u], oe[u], stall[u], done[u]});
        end
        exp_v[0] = 5'b10000;
        exp_v[1] = 5'b10000;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // mode: 0 = bit_en every clock, 1 = every 4th clock, 2 = random
    task automatic run_packet(input int u, input bit sf, input int mode,
                              input int rst_after, input string want);
        int k, bi, cyc, n, L, o;
        bit en;
        string tr, ms;
        o = 1 - u;
        build_model(u, sf);
        n = pb.size();
        L = sym_lvl.size();
        stuff_en[u] = sf;
        k = 0; bi = 0; cyc = 0; tr = "";
        while (k <= L) begin
            if (cyc >= 4000) begin
                miscompares++;
                $display("FAIL timeout_u%0d strobes got %0d required %0d", u, k, L + 1);
                break;
            end
            if (k < L && sym_dat[k]) begin
                bit_in[u] = pb[bi];
                last[u]   = (bi == n - 1);
                start[u]  = (k == 0);
            end else if (k > 0) begin
                start[u] = 1'($urandom_range(0, 1));
            end
            en = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 4 == 3) : 1'($urandom_range(0, 1));
            bit_en[u] = en;
            @(posedge clk);
            #1;
            cyc++;
            exp_v[o][0] = 1'b0;
            if (en) begin
                if (k < L) begin
                    tr = {tr, ch({dp[u], dm[u]})};
                    exp_v[u] = {sym_lvl[k], 1'b1, !((k + 1 < L) && sym_dat[k + 1]), 1'b0};
                    if (sym_dat[k]) bi++;
                end else begin
                    exp_v[u] = 5'b10001;
                end
                k++;
                if (rst_after >= 0 && bi == rst_after && k < L) begin
                    do_reset(u);
                    return;
                end
            end else begin
                exp_v[u][0] = 1'b0;
            end
        end
        bit_en[u] = 1'b0;
        start[u]  = 1'b0;
        if (want != "") begin
            ms = "";
            foreach (sym_lvl[i]) ms = {ms, ch(sym_lvl[i])};
            vectors++;
            if (ms != want) begin
                miscompares++;
                $display("FAIL model_pin_u%0d got %s expected %s", u, ms, want);
            end
            vectors++;
            if (tr != want) begin
                miscompares++;
                $display("FAIL line_trace_u%0d got %s expected %s", u, tr, want);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            start[0]  = 1'b0;
            start[1]  = 1'b0;
            bit_en[0] = 1'($urandom_range(0, 1));
            bit_en[1] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            exp_v[0][0] = 1'b0;
            exp_v[1][0] = 1'b0;
        end
        bit_en[0] = 1'b0;
        bit_en[1] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            bit_en[u] = 1'b0; start[u] = 1'b0; last[u] = 1'b0;
            bit_in[u] = 1'b0; stuff_en[u] = 1'b0;
            exp_v[u] = 5'b10000;
        end
        #3;
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if ({dp[u], dm[u], oe[u], stall[u], done[u]} !== 5'b10000) begin
                miscompares++;
                $display("FAIL reset_state_u%0d got %b expected 10000",
                         u, {dp[u], dm[u], oe[u], stall[u], done[u]});
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle(3);

        load(32'b1111_1110, 8);   run_packet(0, 1'b1, 0, -1, "KKKKKKKJJ00J");  idle(3);
        load(32'b111_1110, 7);    run_packet(0, 1'b1, 0, -1, "KKKKKKKJ00J");   idle(3);
        load(32'b1_1111_1110, 9); run_packet(0, 1'b0, 0, -1, "KKKKKKKKK00J");  idle(3);
        load(32'b1111_1110, 8);   run_packet(0, 1'b1, 1, -1, "KKKKKKKJJ00J");  idle(3);
        load(32'b1111_1110, 8);   run_packet(0, 1'b1, 0, 3, "");               idle(3);
        load(32'b1111_1110, 8);   run_packet(0, 1'b1, 0, -1, "KKKKKKKJJ00J");  idle(2);
        load(32'b1, 1);           run_packet(0, 1'b1, 0, -1, "J00J");          idle(2);
        load(32'b1111, 4);        run_packet(1, 1'b1, 0, -1, "JJJKK000J");     idle(3);
        load(32'b1111, 4);        run_packet(1, 1'b1, 2, 2, "");               idle(2);

        for (int p = 0; p < 50; p++) begin
            int u, n;
            u = p % 2;
            n = $urandom_range(1, 20);
            pb.delete();
            for (int i = 0; i < n; i++) pb.push_back($urandom_range(0, 3) != 0);
            run_packet(u, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 2), -1, "");
            idle($urandom_range(0, 3));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_tx_line_encoder.md
Name: usb_tx_line_encoder

Overview:
- Parametrised successor to the fixed 6-ones bit stuffer and NRZI stage.
- Combines, in one registered block:
  - bit stuffing with a configurable run length and a per-packet bypass mode;
  - NRZI encoding onto a differential dp/dm pair;
  - automatic EOP generation (SE0 then J);
  - a bit-rate enable, so the block runs off a fast system clock.
- Sits between the packet bit stream encoder (upstream, obeys stall) and the USB line driver.

Parameters:
- RUN_LEN, 6, consecutive 1s after which a 0 is stuffed; legal 2..15.
- EOP_SE0_BITS, 2, SE0 bit times in EOP; legal 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- bit_en  in  1  bit-time strobe; state advances only on clocks with bit_en=1.
- start  in  1  marks first bit of packet; sampled in IDLE.
- last  in  1  marks final bit of packet.
- bit_in  in  1  raw (unstuffed) bit.
- stuff_en  in  1  1 = stuffing on, 0 = bypass; latched on start.
- stall  out  1  upstream must hold bit_in/last and not advance.
- dp  out  1  D+ line level.
- dm  out  1  D- line level.
- oe  out  1  driver output enable.
- done  out  1  one-clock pulse when EOP completes.

Behaviour:
- States: IDLE, DATA, STUFF, EOP_SE0, EOP_J.
- Reset (async, immediate, including mid-packet): state=IDLE, dp=1, dm=0 (J), oe=0, stall=0, done=0, run count=0, NRZI level=J, last_pending=0. No done pulse on reset abort.
- bit_en=0: all registers hold; done deasserts.
- Line encoding:
  - J = dp1/dm0, K = dp0/dm1, SE0 = dp0/dm0.
  - NRZI: bit 0 toggles J<->K; bit 1 holds the level.
- dp/dm/oe are registered. A bit accepted on a bit_en clock appears on the line from the next clock and holds until the next bit_en clock.
- stall is combinational from the state register: 1 in STUFF, EOP_SE0 and EOP_J; 0 in IDLE and DATA.
- IDLE:
  - On bit_en && start: accept bit_in, latch stuff_en, oe=1, run = bit_in ? 1 : 0.
  - Next state: DATA. If stuffing is on and the run hits RUN_LEN, go to STUFF instead, as below.
  - start in any other state is ignored.
- DATA, each bit_en: accept bit_in and encode it.
  - Bit 1: run+1. Bit 0: run=0.
  - If stuffing is on and run reaches RUN_LEN: next state STUFF, last_pending=last.
  - Else if last: next state EOP_SE0.
- STUFF, on bit_en: emit 0 (toggle), run=0. Next state EOP_SE0 if last_pending, else DATA. Upstream is stalled for exactly this bit time.
- Bypass (stuff_en latched 0): run is held at 0; STUFF is never entered.
- EOP_SE0:
  - Drive SE0 for EOP_SE0_BITS bit times; counter counts bit_en strobes.
  - Then EOP_J: drive J for one bit time.
  - Then IDLE: oe=0, NRZI level=J, done=1 for one clock.
- start and last on the same bit is a legal single-bit packet.
- A run spanning the last bit still stuffs before EOP.

Test Plan:
- RUN_LEN=6, bit_en=1, stuff_en=1. Input 0,1,1,1,1,1,1,1 (start on first bit, last on final bit).
  -> line K×7, J (stuff), J, SE0, SE0, J, then oe=0 with done pulse.
  -> stall high exactly one clock, after the 6th 1.
- Same input, but last on the 6th 1 (7 bits total).
  -> K×7, J (stuffed bit still sent), SE0×2, J, done.
- stuff_en=0 at start, input 0 then 8 ones (last on final).
  -> stall never asserts; K×9, SE0×2, J.
- bit_en every 4th clock, stream from the first scenario.
  -> each line state held 4 clocks; stall held 4 clocks until the stuff bit emits; done is 1 clock wide.
- rst pulsed after the 3rd bit.
  -> next clock dp=1, dm=0, oe=0, stall=0, no done.
  -> a following start sends a fresh packet correctly.
- RUN_LEN=3, EOP_SE0_BITS=3, input 1,1,1,1 (start on first bit, last on final bit).
  -> stuff after the 3rd 1; line J,J,J,K,K, SE0×3, J.
